pipe_fwd_tracker: RTL and testbench
===================================

Name: pipe_fwd_tracker

Overview:
- Parametrised hazard and bypass block for the in-order MIPS pipeline.
- Generalises the fixed 2-bit EXE/MEM/WB forwarding muxes to DEPTH tracked post-issue stages, NRD operand read ports, and configurable load latency.
- Records the destination of every issued instruction, shifts those records down the pipe, selects the youngest ready producer for each ID-stage operand, and raises a load-use stall when that producer's data is not ready yet.
- Sits between ID-stage decode, the regfile read ports, and the per-stage result buses.

Parameters:
- DATA_W, 32, operand/result width.
- ADDR_W, 5, register address width.
- DEPTH, 3, tracked stages after issue (0 = EXE, DEPTH-1 = WB).
- NRD, 2, number of operand read ports.
- LOAD_STAGE, 1, first stage index whose data bus carries valid load data (1 = MEM output).
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- issue_valid  in  1  ID instruction is valid this cycle.
- issue_wen  in  1  instruction writes a register.
- issue_waddr  in  ADDR_W  destination register.
- issue_load  in  1  result comes from memory.
- rd_addr  in  NRD*ADDR_W  operand addresses; port p uses bits [p*ADDR_W +: ADDR_W].
- rf_data  in  NRD*DATA_W  regfile read data per port.
- stage_data  in  DEPTH*DATA_W  result currently produced by stage s.
- hold  in  1  external freeze (memory wait).
- flush  in  1  kill the instruction entering stage 0 (taken branch).
- fwd_data  out  NRD*DATA_W  resolved operand per port.
- fwd_hit  out  NRD*(DEPTH+1)  one-hot source per port; bit s = stage s, bit DEPTH = regfile.
- stall_req  out  1  ID must hold; a bubble is inserted.
- issue_ack  out  1  issue is accepted into stage 0 this cycle.
- stall_cnt  out  CNT_W  saturating count of stall_req cycles.

Behaviour:
- Reset (asynchronous, rst=1): all stage records are cleared (valid=0, wen=0, waddr=0, load=0) and stall_cnt=0. Combinational outputs then settle to: fwd_data=rf_data, fwd_hit = bit DEPTH only, stall_req=0.
- Stage record s holds {valid, wen, waddr, load}.
- A record matches port p when: valid & wen & waddr==rd_addr[p] & rd_addr[p]!=0.
- A record is ready when: !load, or s >= LOAD_STAGE.
- Source selection, port p, combinational:
  - Pick the lowest-index matching stage (the youngest producer).
  - If it is ready: fwd_data = stage_data[s], fwd_hit bit s.
  - If none matches: use rf_data, bit DEPTH.
  - Register 0 always reads rf_data.
  - A write in the WB stage (DEPTH-1) therefore bypasses a same-cycle regfile read.
- Stall: stall_req=1 when any port's youngest match is not ready. An older ready match never masks a younger unready one.
- issue_ack = issue_valid & !stall_req & !hold & !flush.
- Clock edge, hold=1: all records are frozen. stall_cnt still counts when stall_req=1.
- Clock edge, hold=0:
  - Record s+1 takes record s for s = 0..DEPTH-2; record DEPTH-1 is discarded.
  - Record 0 takes the issue fields if issue_ack, otherwise a bubble (valid=0).
- flush and stall_req in the same cycle: a bubble is inserted; flush has no other effect.
- stall_cnt increments on every edge with stall_req=1 and saturates at all-ones (no wrap).
- Latency: forwarding and stall are zero-cycle combinational. A record advances one stage per unheld cycle.
- A load at stage 0 followed by a dependent instruction, with LOAD_STAGE=1, gives exactly one stall cycle.

Test Plan:
- Reset mid-operation: records full, assert rst asynchronously between edges -> stall_req=0 and fwd_hit=bit DEPTH immediately; stall_cnt=0.
- ALU back-to-back: issue add r3 (wen, waddr=3), next cycle rd_addr port0=3, stage_data[0]=0x1234 -> fwd_data0=0x1234, fwd_hit0=0001, no stall.
- Load-use, LOAD_STAGE=1: lw r5, then a read of r5 -> stall_req=1 for 1 cycle and stall_cnt=1. Next cycle fwd_hit=0010 and fwd_data=stage_data[1]=0xDEAD.
- Priority: r7 written in stages 2 and 0 with values 0xAAAA/0xBBBB -> stage 0 (0xBBBB) is chosen. r0 read with r0 tracked -> rf_data is used.
- Hold and flush: hold=1 for 3 cycles -> records are unchanged. flush with issue_valid=1 -> issue_ack=0 and stage 0 gets a bubble.
- Saturation: CNT_W=4, force 20 consecutive stall cycles -> stall_cnt=15.

Source files
------------

// File: rtl/pipe_fwd_tracker.sv
// Hazard/bypass tracker for the in-order pipeline: tracks DEPTH post-issue
// destination records, picks the youngest producer per operand, and raises load-use stalls.
module pipe_fwd_tracker #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int DEPTH      = 3,
    parameter int NRD        = 2,
    parameter int LOAD_STAGE = 1,
    parameter int CNT_W      = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     issue_valid,
    input  logic                     issue_wen,
    input  logic [ADDR_W-1:0]        issue_waddr,
    input  logic                     issue_load,
    input  logic [NRD*ADDR_W-1:0]    rd_addr,
    input  logic [NRD*DATA_W-1:0]    rf_data,
    input  logic [DEPTH*DATA_W-1:0]  stage_data,
    input  logic                     hold,
    input  logic                     flush,
    output logic [NRD*DATA_W-1:0]    fwd_data,
    output logic [NRD*(DEPTH+1)-1:0] fwd_hit,
    output logic                     stall_req,
    output logic                     issue_ack,
    output logic [CNT_W-1:0]         stall_cnt
);

    logic [DEPTH-1:0]        valid_q, valid_d;
    logic [DEPTH-1:0]        wen_q, wen_d;
    logic [DEPTH-1:0]        load_q, load_d;
    logic [DEPTH*ADDR_W-1:0] waddr_q, waddr_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    stall_s;
    logic                    ack_s;

    // Operand source selection and load-use detection
    always_comb begin
        logic              found;
        logic              rdy;
        int                sel;
        logic [ADDR_W-1:0] rd;
        fwd_data = rf_data;
        fwd_hit  = '0;
        stall_s  = 1'b0;
        for (int p = 0; p < NRD; p++) begin
            found = 1'b0;
            rdy   = 1'b1;
            sel   = DEPTH;
            rd    = rd_addr[p*ADDR_W +: ADDR_W];
            // Ascending scan with a found flag keeps the youngest match
            for (int s = 0; s < DEPTH; s++) begin
                if (!found && valid_q[s] && wen_q[s] && rd != '0 &&
                    waddr_q[s*ADDR_W +: ADDR_W] == rd) begin
                    found = 1'b1;
                    sel   = s;
                    rdy   = !load_q[s] || (s >= LOAD_STAGE);
                end else begin
                    found = found;
                end
            end
            if (found && !rdy) begin
                stall_s = 1'b1;
                fwd_hit[p*(DEPTH+1)+DEPTH] = 1'b1;
            end else if (found) begin
                fwd_data[p*DATA_W +: DATA_W] = stage_data[sel*DATA_W +: DATA_W];
                fwd_hit[p*(DEPTH+1)+sel]     = 1'b1;
            end else begin
                fwd_hit[p*(DEPTH+1)+DEPTH] = 1'b1;
            end
        end
    end

    assign ack_s     = issue_valid & ~stall_s & ~hold & ~flush;
    assign stall_req = stall_s;
    assign issue_ack = ack_s;
    assign stall_cnt = cnt_q;

    // Record shift / freeze and saturating stall counter next state
    always_comb begin
        valid_d = valid_q;
        wen_d   = wen_q;
        load_d  = load_q;
        waddr_d = waddr_q;
        if (!hold) begin
            for (int s = 1; s < DEPTH; s++) begin
                valid_d[s]                  = valid_q[s-1];
                wen_d[s]                    = wen_q[s-1];
                load_d[s]                   = load_q[s-1];
                waddr_d[s*ADDR_W +: ADDR_W] = waddr_q[(s-1)*ADDR_W +: ADDR_W];
            end
            if (ack_s) begin
                valid_d[0]          = 1'b1;
                wen_d[0]            = issue_wen;
                load_d[0]           = issue_load;
                waddr_d[ADDR_W-1:0] = issue_waddr;
            end else begin
                valid_d[0]          = 1'b0;
                wen_d[0]            = 1'b0;
                load_d[0]           = 1'b0;
                waddr_d[ADDR_W-1:0] = '0;
            end
        end else begin
            valid_d = valid_q;
        end
        if (stall_s && cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            wen_q   <= '0;
            load_q  <= '0;
            waddr_q <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            wen_q   <= wen_d;
            load_q  <= load_d;
            waddr_q <= waddr_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_fwd_tracker.sv
// Self-checking bench for pipe_fwd_tracker: vector table through a scoreboard queue,
// then hand-written async-reset and counter-saturation sequences.
module tb_pipe_fwd_tracker;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int DP = 3;
    localparam int NR = 2;
    localparam int CW = 4;

    localparam logic [31:0] R0 = 32'hF0F0_0000;
    localparam logic [31:0] R1 = 32'h0F0F_0001;
    localparam logic [31:0] D0 = 32'h5000_0000;
    localparam logic [31:0] D1 = 32'h5111_1111;
    localparam logic [31:0] D2 = 32'h5222_2222;

    logic                 clk;
    logic                 rst;
    logic                 issue_valid, issue_wen, issue_load, hold, flush;
    logic [AW-1:0]        issue_waddr;
    logic [NR*AW-1:0]     rd_addr;
    logic [NR*DW-1:0]     rf_data;
    logic [DP*DW-1:0]     stage_data;
    logic [NR*DW-1:0]     fwd_data;
    logic [NR*(DP+1)-1:0] fwd_hit;
    logic                 stall_req, issue_ack;
    logic [CW-1:0]        stall_cnt;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic        iv;
        logic        iw;
        logic [4:0]  ia;
        logic        il;
        logic [4:0]  r0;
        logic [4:0]  r1;
        logic [31:0] s0;
        logic [31:0] s1;
        logic [31:0] s2;
        logic        hd;
        logic        fl;
        logic        x0;
        logic [31:0] e0;
        logic [31:0] e1;
        logic [3:0]  h0;
        logic [3:0]  h1;
        logic        est;
        logic        eack;
        logic [3:0]  ecnt;
    } vec_t;

    localparam int NV = 23;
    vec_t vecs [NV];
    vec_t exp_q [$];

    pipe_fwd_tracker #(
        .DATA_W(DW), .ADDR_W(AW), .DEPTH(DP), .NRD(NR), .LOAD_STAGE(1), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_wen(issue_wen), .issue_waddr(issue_waddr),
        .issue_load(issue_load), .rd_addr(rd_addr), .rf_data(rf_data),
        .stage_data(stage_data), .hold(hold), .flush(flush),
        .fwd_data(fwd_data), .fwd_hit(fwd_hit), .stall_req(stall_req),
        .issue_ack(issue_ack), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic iw, input logic [4:0] ia, input logic il,
                         input logic [4:0] r0, input logic [4:0] r1, input logic hd);
        issue_valid = iv; issue_wen = iw; issue_waddr = ia; issue_load = il;
        rd_addr = {r1, r0}; hold = hd; flush = 1'b0;
    endtask

    initial begin
        vec_t v;
        rst = 1'b1;
        rf_data = {R1, R0};
        stage_data = {D2, D1, D0};
        drive(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0);

        //            iv   iw   ia     il   r0     r1     s0            s1            s2            hd   fl   x0   e0            e1            h0       h1       st   ack  cnt
        vecs[0]  = '{1'b0,1'b0,5'd0 ,1'b0,5'd3 ,5'd0 ,D0          ,D1          ,D2          ,1'b0,1'b0,1'b0,R0          ,R1          ,4'b1000,4'b1000,1'b0,1'b0,4'd0};
        vecs[1]  = '{1'b1,1'b1,5'd3 ,1'b0,5'd0 ,5'd0 ,D0          ,D1          ,D2          ,1'b0,1'b0,1'b0,R0          ,R1          ,4'b1000,4'b1000,1'b0,1'b1,4'd0};
        vecs[2]  = '{1'b1,1'b1,5'd5 ,1'b1,5'd3 ,5'd0 ,32'h1234    ,D1          ,D2          ,1'b0,1'b0,1'b0,32'h1234    ,R1          ,4'b0001,4'b1000,1'b0,1'b1,4'd0};
        vecs[3]  = '{1'b1,1'b1,5'd6 ,1'b0,5'd5 ,5'd3 ,D0          ,D1          ,D2          ,1'b0,1'b0,1'b1,R0          ,D1          ,4'b0000,4'b0010,1'b1,1'b0,4'd0};
        vecs[4]  = '{1'b1,1'b1,5'd6 ,1'b0,5'd5 ,5'd3 ,D0          ,32'hDEAD    ,32'h3333    ,1'b0,1'b0,1'b0,32'hDEAD    ,32'h3333    ,4'b0010,4'b0100,1'b0,1'b1,4'd1};
        vecs[5]  = '{1'b1,1'b1,5'd7 ,1'b0,5'd6 ,5'd5 ,D0          ,D1          ,D2          ,1'b0,1'b0,1'b0,D0          ,D2          ,4'b0001,4'b0100,1'b0,1'b1,4'd1};
        vecs[6]  = '{1'b1,1'b1,5'd9 ,1'b0,5'd7 ,5'd0 ,D0          ,D1          ,D2          ,1'b0,1'b0,1'b0,D0          ,R1          ,4'b0001,4'b1000,1'b0,1'b1,4'd1};
        vecs[7]  = '{1'b1,1'b1,5'd7 ,1'b0,5'd7 ,5'd6 ,D0          ,D1          ,D2          ,1'b0,1'b0,1'b0,D1          ,D2          ,4'b0010,4'b0100,1'b0,1'b1,4'd1};
        vecs[8]  = '{1'b1,1'b1,5'd0 ,1'b0,5'd7 ,5'd9 ,32'hBBBB    ,D1          ,32'hAAAA    ,1'b0,1'b0,1'b0,32'hBBBB    ,D1          ,4'b0001,4'b0010,1'b0,1'b1,4'd1};
        vecs[9]  = '{1'b0,1'b0,5'd0 ,1'b0,5'd0 ,5'd7 ,D0          ,D1          ,D2          ,1'b0,1'b0,1'b0,R0          ,D1          ,4'b1000,4'b0010,1'b0,1'b0,4'd1};
        vecs[10] = '{1'b1,1'b1,5'd10,1'b0,5'd7 ,5'd0 ,D0          ,D1          ,D2          ,1'b0,1'b1,1'b0,D2          ,R1          ,4'b0100,4'b1000,1'b0,1'b0,4'd1};
        vecs[11] = '{1'b0,1'b0,5'd0 ,1'b0,5'd10,5'd7 ,D0          ,D1          ,D2          ,1'b0,1'b0,1'b0,R0          ,R1          ,4'b1000,4'b1000,1'b0,1'b0,4'd1};
        vecs[12] = '{1'b1,1'b1,5'd12,1'b1,5'd0 ,5'd0 ,D0          ,D1          ,D2          ,1'b0,1'b0,1'b0,R0          ,R1          ,4'b1000,4'b1000,1'b0,1'b1,4'd1};
        vecs[13] = '{1'b1,1'b1,5'd13,1'b0,5'd12,5'd0 ,D0          ,D1          ,D2          ,1'b1,1'b0,1'b1,R0          ,R1          ,4'b0000,4'b1000,1'b1,1'b0,4'd1};
        vecs[14] = '{1'b1,1'b1,5'd13,1'b0,5'd12,5'd0 ,D0          ,D1          ,D2          ,1'b1,1'b0,1'b1,R0          ,R1          ,4'b0000,4'b1000,1'b1,1'b0,4'd2};
        vecs[15] = '{1'b1,1'b1,5'd13,1'b0,5'd12,5'd0 ,D0          ,D1          ,D2          ,1'b1,1'b0,1'b1,R0          ,R1          ,4'b0000,4'b1000,1'b1,1'b0,4'd3};
        vecs[16] = '{1'b1,1'b1,5'd13,1'b0,5'd12,5'd0 ,D0          ,D1          ,D2          ,1'b0,1'b0,1'b1,R0          ,R1          ,4'b0000,4'b1000,1'b1,1'b0,4'd4};
        vecs[17] = '{1'b0,1'b0,5'd0 ,1'b0,5'd12,5'd0 ,D0          ,D1          ,D2          ,1'b0,1'b0,1'b0,D1          ,R1          ,4'b0010,4'b1000,1'b0,1'b0,4'd5};
        vecs[18] = '{1'b1,1'b1,5'd14,1'b0,5'd0 ,5'd0 ,D0          ,D1          ,D2          ,1'b1,1'b0,1'b0,R0          ,R1          ,4'b1000,4'b1000,1'b0,1'b0,4'd5};
        vecs[19] = '{1'b0,1'b0,5'd0 ,1'b0,5'd12,5'd14,D0          ,D1          ,D2          ,1'b0,1'b0,1'b0,D2          ,R1          ,4'b0100,4'b1000,1'b0,1'b0,4'd5};
        vecs[20] = '{1'b1,1'b1,5'd15,1'b1,5'd0 ,5'd0 ,D0          ,D1          ,D2          ,1'b0,1'b0,1'b0,R0          ,R1          ,4'b1000,4'b1000,1'b0,1'b1,4'd5};
        vecs[21] = '{1'b1,1'b1,5'd16,1'b0,5'd15,5'd0 ,D0          ,D1          ,D2          ,1'b0,1'b1,1'b1,R0          ,R1          ,4'b0000,4'b1000,1'b1,1'b0,4'd5};
        vecs[22] = '{1'b0,1'b0,5'd0 ,1'b0,5'd15,5'd16,D0          ,D1          ,D2          ,1'b0,1'b0,1'b0,D1          ,R1          ,4'b0010,4'b1000,1'b0,1'b0,4'd6};

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            @(posedge clk);
            #1;
            v = vecs[i];
            drive(v.iv, v.iw, v.ia, v.il, v.r0, v.r1, v.hd);
            flush = v.fl;
            stage_data = {v.s2, v.s1, v.s0};
            exp_q.push_back(v);
            #1;
            v = exp_q.pop_front();
            if (!v.x0) begin
                chk($sformatf("v%0d fwd0", i), fwd_data[31:0], v.e0);
                chk($sformatf("v%0d hit0", i), {28'd0, fwd_hit[3:0]}, {28'd0, v.h0});
            end
            chk($sformatf("v%0d fwd1", i), fwd_data[63:32], v.e1);
            chk($sformatf("v%0d hit1", i), {28'd0, fwd_hit[7:4]}, {28'd0, v.h1});
            chk($sformatf("v%0d stall", i), {31'd0, stall_req}, {31'd0, v.est});
            chk($sformatf("v%0d ack", i), {31'd0, issue_ack}, {31'd0, v.eack});
            chk($sformatf("v%0d cnt", i), {28'd0, stall_cnt}, {28'd0, v.ecnt});
        end

        // Asynchronous reset between edges with an unready load tracked
        stage_data = {D2, D1, D0};
        @(posedge clk); #1;
        drive(1'b1, 1'b1, 5'd5, 1'b1, 5'd0, 5'd0, 1'b0);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 5'd0, 1'b0, 5'd5, 5'd0, 1'b0);
        #1;
        chk("pre_rst stall", {31'd0, stall_req}, 32'd1);
        chk("pre_rst cnt", {28'd0, stall_cnt}, 32'd6);
        #2 rst = 1'b1;
        #1;
        chk("rst stall", {31'd0, stall_req}, 32'd0);
        chk("rst hit0", {28'd0, fwd_hit[3:0]}, 32'h8);
        chk("rst fwd0", fwd_data[31:0], R0);
        chk("rst cnt", {28'd0, stall_cnt}, 32'd0);
        #2 rst = 1'b0;

        // Saturation: a held unready load keeps stalling
        @(posedge clk); #1;
        drive(1'b1, 1'b1, 5'd5, 1'b1, 5'd0, 5'd0, 1'b0);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 5'd0, 1'b0, 5'd5, 5'd0, 1'b1);
        repeat (14) @(posedge clk);
        #1;
        chk("sat cnt14", {28'd0, stall_cnt}, 32'd14);
        repeat (6) @(posedge clk);
        #1;
        chk("sat cnt20", {28'd0, stall_cnt}, 32'd15);
        chk("sat stall", {31'd0, stall_req}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
